// File: rtl/forward_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: operand-select encodings, the
// per-stage shadow slot record and the stall FSM states.
package forward_hazard_unit_pkg;

  localparam int unsigned RegW = 3;
  localparam int unsigned CntW = 16;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [RegW-1:0] rd;
    logic            regwrite;
    logic            memread;
  } slot_t;

  typedef enum logic [1:0] {
    StRun,
    StLdStall,
    StMemWait
  } state_e;

  // True when a live, register-writing slot targets the given source register.
  function automatic logic slot_writes(input logic use_src, input logic [RegW-1:0] src,
                                       input slot_t slot);
    return use_src & slot.valid & slot.regwrite & (slot.rd == src);
  endfunction

  // EX/MEM wins over MEM/WB; a load still in EX cannot forward (load-use stall covers it).
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [RegW-1:0] src,
                                         input slot_t ex, input slot_t mem);
    logic [1:0] sel;
    sel = FWD_REG;
    if (slot_writes(use_src, src, ex) && !ex.memread) begin
      sel = FWD_EXMEM;
    end else if (slot_writes(use_src, src, mem)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One shadow pipeline slot: holds while frozen, loads on advance, or loads an
// empty bubble when requested.
module hazard_slot
  import forward_hazard_unit_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  advance_i,
  input  logic  bubble_i,
  input  slot_t slot_i,
  output slot_t slot_o
);

  slot_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (advance_i) begin
      slot_d = bubble_i ? '0 : slot_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding and hazard control for a 5-stage pipeline: tracks the
// destinations in EX/MEM/WB, picks forwarding sources and raises stalls/flushes.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [RegW-1:0] id_rs_i,
  input  logic [RegW-1:0] id_rt_i,
  input  logic            id_use_rs_i,
  input  logic            id_use_rt_i,
  input  logic [RegW-1:0] id_rd_i,
  input  logic            id_regwrite_i,
  input  logic            id_memread_i,
  input  logic            ex_branch_taken_i,
  input  logic            mem_stall_i,
  output logic [1:0]      forward_a_o,
  output logic [1:0]      forward_b_o,
  output logic            pc_hold_o,
  output logic            id_ex_bubble_o,
  output logic            flush_o,
  output logic [CntW-1:0] stall_count_o
);

  slot_t id_slot, ex_slot, mem_slot, wb_slot;

  logic advance;
  logic load_use;
  logic pc_hold;
  logic id_ex_bubble;

  logic [1:0]      fwd_a_q, fwd_a_d;
  logic [1:0]      fwd_b_q, fwd_b_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign advance = ~mem_stall_i;

  assign id_slot = '{
    valid:    id_valid_i,
    rd:       id_rd_i,
    regwrite: id_regwrite_i,
    memread:  id_memread_i
  };

  hazard_slot u_slot_ex (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .advance_i (advance),
    .bubble_i  (id_ex_bubble),
    .slot_i    (id_slot),
    .slot_o    (ex_slot)
  );

  hazard_slot u_slot_mem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .advance_i (advance),
    .bubble_i  (1'b0),
    .slot_i    (ex_slot),
    .slot_o    (mem_slot)
  );

  hazard_slot u_slot_wb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .advance_i (advance),
    .bubble_i  (1'b0),
    .slot_i    (mem_slot),
    .slot_o    (wb_slot)
  );

  // WB mirrors MEM/WB for completeness; nothing downstream of it forwards here.
  logic unused_wb;
  assign unused_wb = ^{wb_slot, mem_slot.memread};

  // Gated by reset so stale slot contents cannot raise a stall in the reset cycle.
  assign load_use = ~rst_i & id_valid_i & ex_slot.memread &
                    (slot_writes(id_use_rs_i, id_rs_i, ex_slot) |
                     slot_writes(id_use_rt_i, id_rt_i, ex_slot));

  assign pc_hold      = mem_stall_i | (load_use & ~ex_branch_taken_i);
  assign id_ex_bubble = ~mem_stall_i & (load_use | ex_branch_taken_i);

  assign pc_hold_o      = pc_hold;
  assign id_ex_bubble_o = id_ex_bubble;
  assign flush_o        = ~mem_stall_i & ex_branch_taken_i;

  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (advance) begin
      if (id_ex_bubble) begin
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
      end else begin
        fwd_a_d = fwd_sel(id_use_rs_i, id_rs_i, ex_slot, mem_slot);
        fwd_b_d = fwd_sel(id_use_rt_i, id_rt_i, ex_slot, mem_slot);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (mem_stall_i) begin
      state_d = StMemWait;
    end else begin
      case (state_q)
        StRun:     if (load_use && !ex_branch_taken_i) state_d = StLdStall;
        StLdStall: state_d = StRun;
        StMemWait: state_d = StRun;
        default:   state_d = StRun;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pc_hold && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign forward_a_o   = fwd_a_q;
  assign forward_b_o   = fwd_b_q;
  assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit with a pipeline-occupancy reference model
// compared every cycle, plus hand-computed expectations for each scenario.
module tb_forward_hazard_unit;
  import forward_hazard_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       br, ms;
  logic [1:0] fa, fb;
  logic       pc_hold, bubble, flush;
  logic [15:0] cnt;

  forward_hazard_unit dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .id_valid_i        (id_valid),
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .id_use_rs_i       (id_use_rs),
    .id_use_rt_i       (id_use_rt),
    .id_rd_i           (id_rd),
    .id_regwrite_i     (id_regwrite),
    .id_memread_i      (id_memread),
    .ex_branch_taken_i (br),
    .mem_stall_i       (ms),
    .forward_a_o       (fa),
    .forward_b_o       (fb),
    .pc_hold_o         (pc_hold),
    .id_ex_bubble_o    (bubble),
    .flush_o           (flush),
    .stall_count_o     (cnt)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at t=%0t", name, got, want, $time);
    end
  endtask

  // Reference model: which instruction sits in each later stage.
  typedef struct {
    bit v;
    int rd;
    bit w;
    bit l;
  } minst_t;

  minst_t m_ex  = '{v: 0, rd: 0, w: 0, l: 0};
  minst_t m_mem = '{v: 0, rd: 0, w: 0, l: 0};
  minst_t m_wb  = '{v: 0, rd: 0, w: 0, l: 0};
  int     exp_fa = 0, exp_fb = 0, exp_cnt = 0;
  state_e exp_st = StRun;

  function automatic bit produces(bit use_r, int r, minst_t s);
    return use_r && s.v && s.w && (s.rd == r);
  endfunction

  function automatic bit m_load_use();
    return !rst && id_valid && m_ex.l &&
           (produces(id_use_rs, int'(id_rs), m_ex) || produces(id_use_rt, int'(id_rt), m_ex));
  endfunction

  function automatic int m_fwd(bit use_r, int r);
    if (produces(use_r, r, m_ex) && !m_ex.l) return 2;
    if (produces(use_r, r, m_mem)) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit lu, hold, bub;
    if (rst) begin
      m_ex = '{v: 0, rd: 0, w: 0, l: 0};
      m_mem = m_ex;
      m_wb = m_ex;
      exp_fa = 0;
      exp_fb = 0;
      exp_cnt = 0;
      exp_st = StRun;
    end else begin
      lu   = m_load_use();
      hold = ms || (lu && !br);
      bub  = !ms && (lu || br);
      if (ms) exp_st = StMemWait;
      else if (exp_st == StRun && lu && !br) exp_st = StLdStall;
      else exp_st = StRun;
      if (hold && exp_cnt < 65535) exp_cnt++;
      if (!ms) begin
        exp_fa = bub ? 0 : m_fwd(id_use_rs, int'(id_rs));
        exp_fb = bub ? 0 : m_fwd(id_use_rt, int'(id_rt));
        m_wb  = m_mem;
        m_mem = m_ex;
        if (bub) m_ex = '{v: 0, rd: 0, w: 0, l: 0};
        else m_ex = '{v: id_valid, rd: int'(id_rd), w: id_regwrite, l: id_memread};
      end
    end
  end

  always @(negedge clk) begin
    bit lu;
    if (chk_en) begin
      lu = m_load_use();
      check("model_fwdA", int'(fa), exp_fa);
      check("model_fwdB", int'(fb), exp_fb);
      check("model_pc_hold", int'(pc_hold), int'(ms || (lu && !br)));
      check("model_bubble", int'(bubble), int'(!ms && (lu || br)));
      check("model_flush", int'(flush), int'(!ms && br));
      check("model_count", int'(cnt), exp_cnt);
      check("model_state", int'(dut.state_q), int'(exp_st));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                     input int rd, input bit rw, input bit mr);
    id_valid    = v;
    id_rs       = 3'(rs);
    id_use_rs   = urs;
    id_rt       = 3'(rt);
    id_use_rt   = urt;
    id_rd       = 3'(rd);
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic nop();
    ins(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    br  = 1'b0;
    ms  = 1'b0;
    nop();
    next();
    chk_en = 1'b1;
    // Reset cycle with a valid instruction that would otherwise look like a hazard source
    ins(1, 0, 1, 0, 1, 0, 1, 1);
    @(negedge clk);
    check("rst_pc_hold", int'(pc_hold), 0);
    check("rst_bubble", int'(bubble), 0);
    check("rst_flush", int'(flush), 0);
    check("rst_fwdA", int'(fa), 0);
    check("rst_count", int'(cnt), 0);
    next();
    rst = 1'b0;
    nop();
    @(negedge clk);
    check("rst_state", int'(dut.state_q), int'(StRun));

    // ADD r1 ; ADD r2,r1,r3 -> forwardA = EX/MEM
    next();
    ins(1, 6, 1, 7, 1, 1, 1, 0);
    next();
    ins(1, 1, 1, 3, 1, 2, 1, 0);
    @(negedge clk);
    check("exmem_no_hold", int'(pc_hold), 0);
    next();
    nop();
    @(negedge clk);
    check("exmem_fwdA", int'(fa), 2);
    check("exmem_fwdB", int'(fb), 0);

    // ADD r1 ; NOP ; SUB r4,r5,r1 -> forwardB = MEM/WB
    next();
    ins(1, 6, 1, 7, 1, 1, 1, 0);
    next();
    nop();
    next();
    ins(1, 5, 1, 1, 1, 4, 1, 0);
    next();
    nop();
    @(negedge clk);
    check("wb_fwdB", int'(fb), 1);
    check("wb_fwdA", int'(fa), 0);

    // LD r2 ; ADD r3,r2,r2 -> one stall cycle, then both operands from MEM/WB
    next();
    ins(1, 6, 1, 0, 0, 2, 1, 1);
    next();
    ins(1, 2, 1, 2, 1, 3, 1, 0);
    @(negedge clk);
    check("ldu_pc_hold", int'(pc_hold), 1);
    check("ldu_bubble", int'(bubble), 1);
    check("ldu_flush", int'(flush), 0);
    next();
    @(negedge clk);
    check("ldu_hold_once", int'(pc_hold), 0);
    check("ldu_bubble_once", int'(bubble), 0);
    check("ldu_state", int'(dut.state_q), int'(StLdStall));
    next();
    nop();
    @(negedge clk);
    check("ldu_fwdA", int'(fa), 1);
    check("ldu_fwdB", int'(fb), 1);
    check("ldu_count", int'(cnt), 1);
    check("ldu_state_back", int'(dut.state_q), int'(StRun));

    // Load-use coinciding with a taken branch: branch wins
    next();
    ins(1, 6, 1, 0, 0, 2, 1, 1);
    next();
    ins(1, 2, 1, 2, 1, 3, 1, 0);
    br = 1'b1;
    @(negedge clk);
    check("br_flush", int'(flush), 1);
    check("br_bubble", int'(bubble), 1);
    check("br_pc_hold", int'(pc_hold), 0);
    next();
    br = 1'b0;
    nop();
    @(negedge clk);
    check("br_state", int'(dut.state_q), int'(StRun));
    check("br_count", int'(cnt), 1);
    check("br_fwdA", int'(fa), 0);

    // mem_stall for 3 cycles while a forward is presented; branch held until advance
    next();
    ins(1, 6, 1, 7, 1, 1, 1, 0);
    next();
    ins(1, 1, 1, 3, 1, 2, 1, 0);
    next();
    ins(1, 2, 1, 0, 1, 5, 1, 0);
    ms = 1'b1;
    br = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ms_pc_hold", int'(pc_hold), 1);
      check("ms_fwdA_frozen", int'(fa), 2);
      check("ms_flush_held", int'(flush), 0);
      check("ms_bubble_held", int'(bubble), 0);
      if (i > 0) check("ms_state", int'(dut.state_q), int'(StMemWait));
      next();
    end
    ms = 1'b0;
    @(negedge clk);
    check("ms_state_end", int'(dut.state_q), int'(StMemWait));
    check("ms_count", int'(cnt), 4);
    check("ms_fwdA_end", int'(fa), 2);
    check("ms_br_flush", int'(flush), 1);
    check("ms_br_bubble", int'(bubble), 1);
    check("ms_br_no_hold", int'(pc_hold), 0);
    next();
    br = 1'b0;
    nop();
    @(negedge clk);
    check("ms_after_fwdA", int'(fa), 0);
    check("ms_after_state", int'(dut.state_q), int'(StRun));

    // Reset in the middle of a load-use stall
    next();
    ins(1, 6, 1, 0, 0, 2, 1, 1);
    next();
    ins(1, 2, 1, 2, 1, 3, 1, 0);
    next();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state_pre", int'(dut.state_q), int'(StLdStall));
    check("midrst_count_pre", int'(cnt), 5);
    next();
    rst = 1'b0;
    nop();
    @(negedge clk);
    check("midrst_fwdA", int'(fa), 0);
    check("midrst_fwdB", int'(fb), 0);
    check("midrst_state", int'(dut.state_q), int'(StRun));
    check("midrst_count", int'(cnt), 0);

    // Saturation of the stall counter
    next();
    ms = 1'b1;
    repeat (65535) next();
    @(negedge clk);
    check("sat_reach", int'(cnt), 65535);
    repeat (3) next();
    @(negedge clk);
    check("sat_hold", int'(cnt), 65535);
    check("sat_state", int'(dut.state_q), int'(StMemWait));
    next();
    ms = 1'b0;
    next();
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
